// File: rtl/bwc_pkg.sv
// Shared definitions for the banked write controller: FSM encoding and
// default sizing used by the top and the per-bank address counter.
package bwc_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_BANKS = 2;
  localparam int DEF_ADDR_W    = 15;
  localparam int DEF_LEN_W     = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/bank_addr_counter.sv
// Per-bank write address: steps by one on each write, wraps to zero once the
// current value reaches the last valid address, and can be parked at all-ones.
module bank_addr_counter
  import bwc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              load_ones_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // '>=' rather than '==' so a parked all-ones value (or a shrunk depth) wraps to 0
  always_comb begin
    addr_d = addr_q;
    if (inc_i) begin
      addr_d = (addr_q >= last_addr_i) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load_ones_i) begin
      addr_q <= '1;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/bank_write_control.sv
// Splits a sample stream into packages and round-robins each word across
// NUM_BANKS memory banks, with registered per-bank data/address/write-enable.
module bank_write_control
  import bwc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        live_rising,
  input  logic                        get_package,
  input  logic [DATA_W-1:0]           input_data,
  input  logic [LEN_W-1:0]            words_per_bank,
  input  logic [ADDR_W-1:0]           mem_depth,
  output logic [NUM_BANKS*DATA_W-1:0] bank_data,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS-1:0]        bank_wren,
  output logic                        complete,
  output logic                        busy,
  output logic [15:0]                 pkg_count,
  output logic                        restart_err
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int KW     = LEN_W + BANK_W;

  state_e                state_q;
  logic [KW-1:0]         k_q;
  logic [LEN_W-1:0]      wpb_q;
  logic [ADDR_W-1:0]     depth_q;
  logic [NUM_BANKS-1:0]  wren_q;
  logic                  complete_q;
  logic [15:0]           pkg_count_q;
  logic                  restart_err_q;

  logic                  hdr;
  logic                  is_last;
  logic [KW-1:0]         last_k;
  logic [BANK_W-1:0]     wr_bank;
  logic [NUM_BANKS-1:0]  wr_en;
  logic [ADDR_W-1:0]     last_addr;

  assign hdr       = get_package && (words_per_bank != '0);
  assign last_k    = {wpb_q, {BANK_W{1'b0}}} - KW'(1);
  assign is_last   = (k_q == last_k);
  assign wr_bank   = k_q[BANK_W-1:0];
  assign last_addr = depth_q - ADDR_W'(1);

  // The word sampled this cycle is committed only if nothing is resetting the run
  assign wr_en = (state_q == WRITE && !rst && !live_rising)
               ? (NUM_BANKS'(1) << wr_bank) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      wpb_q         <= '0;
      depth_q       <= '0;
      wren_q        <= '0;
      complete_q    <= 1'b0;
      pkg_count_q   <= '0;
      restart_err_q <= 1'b0;
    end else if (live_rising) begin
      state_q       <= IDLE;
      k_q           <= '0;
      wren_q        <= '0;
      complete_q    <= 1'b0;
      pkg_count_q   <= '0;
      restart_err_q <= 1'b0;
    end else begin
      wren_q     <= wr_en;
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hdr) begin
            wpb_q   <= words_per_bank;
            depth_q <= mem_depth;
            k_q     <= '0;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (is_last) begin
            complete_q  <= 1'b1;
            pkg_count_q <= pkg_count_q + 16'd1;
          end
          if (hdr) begin
            // A header on the final word is a clean back-to-back start
            if (!is_last) begin
              restart_err_q <= 1'b1;
            end
            wpb_q   <= words_per_bank;
            depth_q <= mem_depth;
            k_q     <= '0;
          end else if (is_last) begin
            state_q <= IDLE;
            k_q     <= '0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
        end else if (wr_en[gi]) begin
          data_q <= input_data;
        end
      end

      bank_addr_counter #(
        .ADDR_W(ADDR_W)
      ) u_addr (
        .clk         (clk),
        .load_ones_i (rst | live_rising),
        .inc_i       (wr_en[gi]),
        .last_addr_i (last_addr),
        .addr_o      (bank_addr[gi*ADDR_W +: ADDR_W])
      );

      assign bank_data[gi*DATA_W +: DATA_W] = data_q;
    end
  endgenerate

  assign bank_wren   = wren_q;
  assign complete    = complete_q;
  assign busy        = (state_q == WRITE);
  assign pkg_count   = pkg_count_q;
  assign restart_err = restart_err_q;

endmodule

// File: tb/tb_bank_write_control.sv
// Bench for bank_write_control: a 4-bank instance driven through directed and
// random traffic against a package-level model, plus a 2-bank full-depth wrap.
module tb_bank_write_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bank instance
  logic        a_rst = 1'b1, a_lr = 1'b0, a_gp = 1'b0;
  logic [15:0] a_din = '0;
  logic [9:0]  a_wpb = '0;
  logic [14:0] a_md  = '0;
  logic [63:0] a_data;
  logic [59:0] a_addr;
  logic [3:0]  a_wren;
  logic        a_complete, a_busy, a_err;
  logic [15:0] a_cnt;

  bank_write_control #(.DATA_W(16), .NUM_BANKS(4), .ADDR_W(15), .LEN_W(10)) u_dut_a (
    .clk(clk), .rst(a_rst), .live_rising(a_lr), .get_package(a_gp),
    .input_data(a_din), .words_per_bank(a_wpb), .mem_depth(a_md),
    .bank_data(a_data), .bank_addr(a_addr), .bank_wren(a_wren),
    .complete(a_complete), .busy(a_busy), .pkg_count(a_cnt), .restart_err(a_err)
  );

  // 2-bank instance for the full 2^15 address range
  logic        b_rst = 1'b1, b_lr = 1'b0, b_gp = 1'b0;
  logic [15:0] b_din = '0;
  logic [15:0] b_wpb = '0;
  logic [14:0] b_md  = '0;
  logic [31:0] b_data;
  logic [29:0] b_addr;
  logic [1:0]  b_wren;
  logic        b_complete, b_busy, b_err;
  logic [15:0] b_cnt;

  bank_write_control #(.DATA_W(16), .NUM_BANKS(2), .ADDR_W(15), .LEN_W(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .live_rising(b_lr), .get_package(b_gp),
    .input_data(b_din), .words_per_bank(b_wpb), .mem_depth(b_md),
    .bank_data(b_data), .bank_addr(b_addr), .bank_wren(b_wren),
    .complete(b_complete), .busy(b_busy), .pkg_count(b_cnt), .restart_err(b_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Package-level reference model for the 4-bank instance
  bit          m_busy;
  int          m_k, m_len, m_depth, m_wb, m_cnt;
  bit          m_complete, m_err;
  int          m_addr[4];
  logic [15:0] m_data[4];

  function automatic int next_addr(input int cur, input int depth);
    int eff;
    eff = (depth == 0) ? 32768 : depth;
    return (cur >= eff - 1) ? 0 : cur + 1;
  endfunction

  task automatic model_update(input bit r, input bit l, input bit g,
                              input int wpb, input int md, input logic [15:0] d);
    bit hdr;
    int b;
    m_wb       = -1;
    m_complete = 1'b0;
    hdr        = g && (wpb != 0);
    if (r) begin
      m_busy = 0; m_k = 0; m_len = 0; m_depth = 0; m_cnt = 0; m_err = 0;
      for (int i = 0; i < 4; i++) begin
        m_addr[i] = 32767;
        m_data[i] = '0;
      end
    end else if (l) begin
      m_busy = 0; m_k = 0; m_cnt = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_addr[i] = 32767;
    end else begin
      if (m_busy) begin
        b         = m_k % 4;
        m_data[b] = d;
        m_addr[b] = next_addr(m_addr[b], m_depth);
        m_wb      = b;
        if (m_k == m_len - 1) begin
          m_complete = 1'b1;
          m_cnt      = (m_cnt + 1) % 65536;
          m_busy     = 0;
        end else begin
          m_k++;
          if (hdr) m_err = 1'b1;
        end
      end
      if (hdr) begin
        m_busy  = 1;
        m_k     = 0;
        m_len   = wpb * 4;
        m_depth = md;
      end
    end
  endtask

  task automatic compare_a();
    logic [63:0] ed;
    logic [59:0] ea;
    for (int i = 0; i < 4; i++) begin
      ed[i*16 +: 16] = m_data[i];
      ea[i*15 +: 15] = 15'(m_addr[i]);
    end
    check_eq("a_wren", a_wren, (m_wb < 0) ? 64'd0 : (64'd1 << m_wb));
    check_eq("a_complete", a_complete, m_complete);
    check_eq("a_busy", a_busy, m_busy);
    check_eq("a_pkg_count", a_cnt, 16'(m_cnt));
    check_eq("a_restart_err", a_err, m_err);
    check_eq("a_bank_data", a_data, ed);
    check_eq("a_bank_addr", a_addr, ea);
  endtask

  task automatic step_a(input bit r, input bit l, input bit g, input logic [15:0] d);
    a_rst = r; a_lr = l; a_gp = g; a_din = d;
    @(posedge clk);
    model_update(r, l, g, int'(a_wpb), int'(a_md), d);
    #1;
    compare_a();
    if (m_complete) $display("A: package complete, pkg_count=%0d", m_cnt);
  endtask

  task automatic step_b(input bit r, input bit g, input logic [15:0] d);
    b_rst = r; b_lr = 1'b0; b_gp = g; b_din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a();
    bit r, l, g;
    // reset state
    step_a(1, 0, 0, 0);
    step_a(1, 0, 0, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_wren", a_wren, 0);
    check_eq("rst_addr", a_addr, {4{15'h7fff}});
    step_a(0, 0, 0, 0);

    // single package, words 0..11 across four banks
    a_wpb = 3; a_md = 8;
    step_a(0, 0, 1, 16'hdead);
    for (int k = 0; k < 12; k++) begin
      step_a(0, 0, 0, 16'(k));
      check_eq("s1_wren", a_wren, 64'd1 << (k % 4));
      check_eq("s1_complete", a_complete, (k == 11));
    end
    check_eq("s1_count", a_cnt, 1);
    check_eq("s1_data", a_data, {16'd11, 16'd10, 16'd9, 16'd8});
    check_eq("s1_addr", a_addr, {4{15'd2}});
    step_a(0, 0, 0, 0);
    check_eq("s1_idle", a_busy, 0);
    $display("A: single package scenario done");

    // three back-to-back packages, depth 8
    step_a(0, 1, 0, 0);
    step_a(0, 0, 1, 0);
    for (int w = 0; w < 36; w++) begin
      step_a(0, 0, (w == 11 || w == 23), 16'(w));
      check_eq("s2_busy", a_busy, (w != 35));
      check_eq("s2_addr", (a_addr >> (15 * (w % 4))) & 60'h7fff, (w / 4) % 8);
    end
    check_eq("s2_err", a_err, 0);
    check_eq("s2_count", a_cnt, 3);
    $display("A: back-to-back scenario done");

    // header arriving mid-package
    step_a(0, 1, 0, 0);
    step_a(0, 0, 1, 0);
    for (int c = 1; c <= 4; c++) step_a(0, 0, 0, 16'(c));
    step_a(0, 0, 1, 16'h0055);
    check_eq("s3_old_word_wren", a_wren, 1);
    check_eq("s3_no_complete", a_complete, 0);
    check_eq("s3_err", a_err, 1);
    step_a(0, 0, 0, 16'h0066);
    check_eq("s3_new_wren", a_wren, 1);
    check_eq("s3_new_addr", a_addr[14:0], 2);
    check_eq("s3_new_data", a_data[15:0], 16'h0066);
    for (int w = 1; w < 12; w++) step_a(0, 0, 0, 16'(w));
    check_eq("s3_count", a_cnt, 1);
    check_eq("s3_err_sticky", a_err, 1);

    // live_rising clears the error and rewinds addresses
    step_a(0, 1, 0, 0);
    check_eq("s5_err_clr", a_err, 0);
    check_eq("s5_addr_ones", a_addr, {4{15'h7fff}});
    step_a(0, 0, 1, 0);
    step_a(0, 0, 0, 16'h0077);
    check_eq("s5_first_wren", a_wren, 1);
    check_eq("s5_first_addr", a_addr[14:0], 0);
    for (int w = 1; w < 12; w++) step_a(0, 0, 0, 16'(w));
    $display("A: restart and live_rising scenario done");

    // reset mid-package
    step_a(0, 1, 0, 0);
    step_a(0, 0, 1, 0);
    for (int c = 1; c <= 3; c++) step_a(0, 0, 0, 16'(c));
    step_a(1, 0, 0, 16'd4);
    check_eq("s4_wren", a_wren, 0);
    check_eq("s4_addr", a_addr, {4{15'h7fff}});
    check_eq("s4_count", a_cnt, 0);
    check_eq("s4_busy", a_busy, 0);
    step_a(0, 0, 0, 16'd5);
    check_eq("s4_wren_after", a_wren, 0);
    $display("A: mid-package reset scenario done");

    // zero-length header is ignored
    a_wpb = 0;
    for (int i = 0; i < 4; i++) begin
      step_a(0, 0, (i == 0), 16'(i));
      check_eq("s6_busy", a_busy, 0);
      check_eq("s6_wren", a_wren, 0);
    end
    $display("A: zero-length header scenario done");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a_wpb = 10'($urandom_range(0, 3));
      a_md  = 15'($urandom_range(0, 9));
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 79) == 0);
      g = ($urandom_range(0, 9) == 0);
      step_a(r, l, g, 16'($urandom));
    end
    $display("A: random traffic done");
  endtask

  task automatic run_b();
    step_b(1, 0, 0);
    step_b(1, 0, 0);
    check_eq("b_rst_addr", b_addr, {2{15'h7fff}});
    b_wpb = 16'h8000;
    b_md  = '0;
    step_b(0, 1, 0);
    for (int i = 0; i < 65538; i++) begin
      if (i == 65535) b_wpb = 16'd1;
      step_b(0, (i == 65535), 16'(i));
      check_eq("b_wren", b_wren, 64'd1 << (i % 2));
      check_eq("b_addr", (b_addr >> (15 * (i % 2))) & 30'h7fff, (i / 2) % 32768);
      check_eq("b_complete", b_complete, (i == 65535 || i == 65537));
      if (i == 65535) begin
        check_eq("b_last_addr", b_addr, {2{15'h7fff}});
        $display("B: full-depth package complete");
      end
    end
    check_eq("b_wrap_addr", b_addr, {2{15'h0000}});
    check_eq("b_count", b_cnt, 2);
    check_eq("b_err", b_err, 0);
    check_eq("b_idle", b_busy, 0);
    $display("B: wrap scenario done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
